// File: rtl/fetch_sequencer.sv
// Two-byte instruction fetch sequencer: issues low/high byte reads to a
// byte-wide memory, assembles a little-endian 16-bit instruction and hands
// it to the core with a valid/ack handshake. A branch flush abandons the
// fetch, draining any read that memory has already accepted.
module fetch_sequencer #(
  parameter int unsigned ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_busy,
  output logic [15:0]       inst,
  output logic              inst_valid,
  input  logic              inst_ack,
  input  logic              flush,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [7:0]        mem_rdata
);

  localparam int unsigned INST_W = 16;
  localparam int unsigned BYTE_W = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ_LO  = 3'd1,
    WAIT_LO = 3'd2,
    REQ_HI  = 3'd3,
    WAIT_HI = 3'd4,
    HOLD    = 3'd5,
    DRAIN   = 3'd6
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [BYTE_W-1:0]   lo_q, lo_d;
  logic [INST_W-1:0]   inst_q, inst_d;
  logic                inst_valid_q, inst_valid_d;
  logic                mem_req_q, mem_req_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic                busy_q, busy_d;

  // State and registered outputs; reset abandons any outstanding read.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      lo_q         <= '0;
      inst_q       <= '0;
      inst_valid_q <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      lo_q         <= lo_d;
      inst_q       <= inst_d;
      inst_valid_q <= inst_valid_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      busy_q       <= busy_d;
    end
  end

  // Next-state logic; flush wins over every transition, and goes to DRAIN
  // only when a granted read is still owed a response.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    lo_d         = lo_q;
    inst_d       = inst_q;
    inst_valid_d = inst_valid_q;

    unique case (state_q)
      IDLE: begin
        if (fetch_req && !flush) begin
          addr_d  = fetch_addr;
          state_d = REQ_LO;
        end
      end
      REQ_LO: begin
        if (flush)        state_d = mem_gnt ? DRAIN : IDLE;
        else if (mem_gnt) state_d = WAIT_LO;
      end
      WAIT_LO: begin
        if (flush) begin
          state_d = mem_rvalid ? IDLE : DRAIN;
        end else if (mem_rvalid) begin
          lo_d    = mem_rdata;
          state_d = REQ_HI;
        end
      end
      REQ_HI: begin
        if (flush)        state_d = mem_gnt ? DRAIN : IDLE;
        else if (mem_gnt) state_d = WAIT_HI;
      end
      WAIT_HI: begin
        if (flush) begin
          state_d = mem_rvalid ? IDLE : DRAIN;
        end else if (mem_rvalid) begin
          inst_d       = {mem_rdata, lo_q};
          inst_valid_d = 1'b1;
          state_d      = HOLD;
        end
      end
      HOLD: begin
        if (flush) begin
          inst_valid_d = 1'b0;
          state_d      = IDLE;
        end else if (inst_ack) begin
          inst_valid_d = 1'b0;
          if (fetch_req) begin
            addr_d  = fetch_addr;
            state_d = REQ_LO;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DRAIN: begin
        if (mem_rvalid) state_d = IDLE;
      end
      default: begin
        state_d      = IDLE;
        inst_valid_d = 1'b0;
      end
    endcase
  end

  // Memory-side outputs are derived from the next state so they are registered
  // and line up with the state they belong to; the address holds otherwise.
  always_comb begin
    mem_req_d  = (state_d == REQ_LO) || (state_d == REQ_HI);
    mem_addr_d = mem_addr_q;
    if (state_d == REQ_LO) begin
      mem_addr_d = addr_d;
    end else if (state_d == REQ_HI) begin
      mem_addr_d = addr_d + ADDR_W'(1);
    end
    busy_d = (state_d != IDLE);
  end

  assign fetch_busy = busy_q;
  assign inst       = inst_q;
  assign inst_valid = inst_valid_q;
  assign mem_req    = mem_req_q;
  assign mem_addr   = mem_addr_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a byte-memory model whose grant
// and read-data delays are adjustable per test.
module tb_fetch_sequencer;

  localparam int unsigned ADDR_W = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              fetch_req = 1'b0;
  logic [ADDR_W-1:0] fetch_addr = '0;
  logic              fetch_busy;
  logic [15:0]       inst;
  logic              inst_valid;
  logic              inst_ack = 1'b0;
  logic              flush = 1'b0;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_gnt = 1'b0;
  logic              mem_rvalid = 1'b0;
  logic [7:0]        mem_rdata = 8'h00;

  int checks = 0;
  int failures = 0;

  fetch_sequencer #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_busy(fetch_busy),
    .inst(inst), .inst_valid(inst_valid), .inst_ack(inst_ack), .flush(flush),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory model: grants after gnt_dly idle request cycles, returns data
  // rv_dly cycles after the first cycle following the grant edge.
  logic [7:0]        mem [0:65535];
  int                gnt_dly = 0;
  int                rv_dly = 0;
  int                g_cnt = 0;
  int                rv_cnt = 0;
  logic              pend = 1'b0;
  logic [ADDR_W-1:0] pend_addr = '0;
  logic [ADDR_W-1:0] gaddr = '0;
  logic [ADDR_W-1:0] gnt_log [$];

  always @(negedge clk) begin
    if (mem_gnt) begin
      pend      = 1'b1;
      pend_addr = gaddr;
      rv_cnt    = rv_dly;
    end
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    if (pend) begin
      if (rv_cnt == 0) begin
        mem_rvalid = 1'b1;
        mem_rdata  = mem[pend_addr];
        pend       = 1'b0;
      end else begin
        rv_cnt = rv_cnt - 1;
      end
    end else if (mem_req) begin
      if (g_cnt == 0) begin
        mem_gnt = 1'b1;
        gaddr   = mem_addr;
        gnt_log.push_back(mem_addr);
        g_cnt   = gnt_dly;
      end else begin
        g_cnt = g_cnt - 1;
      end
    end else begin
      g_cnt = gnt_dly;
    end
  end

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!inst_valid && n < 100) begin
      step();
      n++;
    end
    chk_eq({tag, "_valid_timeout"}, 32'(inst_valid), 32'd1);
  endtask

  task automatic wait_pend(input logic [ADDR_W-1:0] a, input string tag);
    int n = 0;
    while (!(pend && pend_addr == a) && n < 100) begin
      step();
      n++;
    end
    chk_eq({tag, "_pend_timeout"}, 32'(pend && pend_addr == a), 32'd1);
  endtask

  task automatic fetch_check(input logic [ADDR_W-1:0] a, input logic [15:0] exp,
                             input logic [ADDR_W-1:0] hi_addr, input string tag);
    gnt_log.delete();
    fetch_req  = 1'b1;
    fetch_addr = a;
    step();
    fetch_req = 1'b0;
    wait_valid(tag);
    chk_eq({tag, "_inst"}, 32'(inst), 32'(exp));
    chk_eq({tag, "_ngnt"}, 32'(gnt_log.size()), 32'd2);
    if (gnt_log.size() >= 2) begin
      chk_eq({tag, "_lo_addr"}, 32'(gnt_log[0]), 32'(a));
      chk_eq({tag, "_hi_addr"}, 32'(gnt_log[1]), 32'(hi_addr));
    end
    inst_ack = 1'b1;
    step();
    inst_ack = 1'b0;
    chk_eq({tag, "_ack_valid"}, 32'(inst_valid), 32'd0);
    chk_eq({tag, "_ack_busy"}, 32'(fetch_busy), 32'd0);
  endtask

  initial begin
    logic saw_valid;
    mem[16'h0010] = 8'ha0; mem[16'h0011] = 8'h0b;
    mem[16'h0002] = 8'h04; mem[16'h0003] = 8'h82;
    mem[16'hFFFF] = 8'hc5; mem[16'h0000] = 8'h44;
    mem[16'h0030] = 8'h11; mem[16'h0031] = 8'hEE;
    mem[16'h0006] = 8'h20; mem[16'h0007] = 8'h02;
    mem[16'h0040] = 8'h99; mem[16'h0041] = 8'h98;
    mem[16'h0050] = 8'h55; mem[16'h0051] = 8'h66;

    // Reset values
    step(); step();
    chk_eq("rst_mem_req", 32'(mem_req), 32'd0);
    chk_eq("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk_eq("rst_inst", 32'(inst), 32'd0);
    chk_eq("rst_valid", 32'(inst_valid), 32'd0);
    chk_eq("rst_busy", 32'(fetch_busy), 32'd0);
    rst = 1'b0;
    step();

    // Single fetch with exact-latency tracking
    fetch_req = 1'b1; fetch_addr = 16'h0010;
    step();
    fetch_req = 1'b0;
    chk_eq("sf_req_lo", 32'(mem_req), 32'd1);
    chk_eq("sf_addr_lo", 32'(mem_addr), 32'h10);
    chk_eq("sf_busy", 32'(fetch_busy), 32'd1);
    step();
    step();
    chk_eq("sf_addr_hi", 32'(mem_addr), 32'h11);
    chk_eq("sf_req_hi", 32'(mem_req), 32'd1);
    step();
    chk_eq("sf_valid_early", 32'(inst_valid), 32'd0);
    step();
    chk_eq("sf_valid_lat", 32'(inst_valid), 32'd1);
    chk_eq("sf_inst", 32'(inst), 32'h0ba0);
    step(); step();
    chk_eq("sf_hold_valid", 32'(inst_valid), 32'd1);
    chk_eq("sf_hold_inst", 32'(inst), 32'h0ba0);

    // Back-to-back: ack plus new request, grant stalled 3 cycles
    gnt_dly = 3;
    gnt_log.delete();
    inst_ack = 1'b1; fetch_req = 1'b1; fetch_addr = 16'h0002;
    step();
    inst_ack = 1'b0; fetch_req = 1'b0;
    chk_eq("b2b_busy", 32'(fetch_busy), 32'd1);
    chk_eq("b2b_valid_drop", 32'(inst_valid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      chk_eq("b2b_stall_req", 32'(mem_req), 32'd1);
      chk_eq("b2b_stall_addr", 32'(mem_addr), 32'h0002);
      step();
    end
    wait_valid("b2b");
    chk_eq("b2b_inst", 32'(inst), 32'h8204);
    inst_ack = 1'b1;
    step();
    inst_ack = 1'b0;
    chk_eq("b2b_idle", 32'(fetch_busy), 32'd0);
    gnt_dly = 0;

    // Address wrap
    fetch_check(16'hFFFF, 16'h44c5, 16'h0000, "wrap");

    // Flush in WAIT_HI with late data
    rv_dly = 3;
    fetch_req = 1'b1; fetch_addr = 16'h0030;
    step();
    fetch_req = 1'b0;
    wait_pend(16'h0031, "fhi");
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk_eq("fhi_drain_busy", 32'(fetch_busy), 32'd1);
    chk_eq("fhi_drain_req", 32'(mem_req), 32'd0);
    saw_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      saw_valid = saw_valid | inst_valid;
      step();
    end
    chk_eq("fhi_no_valid", 32'(saw_valid), 32'd0);
    chk_eq("fhi_idle", 32'(fetch_busy), 32'd0);
    rv_dly = 0;
    fetch_check(16'h0006, 16'h0220, 16'h0007, "post_drain");

    // Flush coinciding with grant in REQ_LO
    rv_dly = 1;
    fetch_req = 1'b1; fetch_addr = 16'h0050;
    step();
    fetch_req = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk_eq("fgnt_drain_busy", 32'(fetch_busy), 32'd1);
    chk_eq("fgnt_req", 32'(mem_req), 32'd0);
    step();
    chk_eq("fgnt_still_drain", 32'(fetch_busy), 32'd1);
    step();
    chk_eq("fgnt_idle", 32'(fetch_busy), 32'd0);
    chk_eq("fgnt_valid", 32'(inst_valid), 32'd0);
    rv_dly = 0;

    // Flush in HOLD
    fetch_req = 1'b1; fetch_addr = 16'h0010;
    step();
    fetch_req = 1'b0;
    wait_valid("fhold");
    chk_eq("fhold_inst", 32'(inst), 32'h0ba0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk_eq("fhold_valid", 32'(inst_valid), 32'd0);
    chk_eq("fhold_busy", 32'(fetch_busy), 32'd0);

    // Fetch request alongside flush in IDLE is dropped
    fetch_req = 1'b1; flush = 1'b1; fetch_addr = 16'h0010;
    step();
    fetch_req = 1'b0; flush = 1'b0;
    chk_eq("idle_flush_busy", 32'(fetch_busy), 32'd0);
    chk_eq("idle_flush_req", 32'(mem_req), 32'd0);

    // Reset in WAIT_LO, then a stray response
    rv_dly = 2;
    fetch_req = 1'b1; fetch_addr = 16'h0040;
    step();
    fetch_req = 1'b0;
    wait_pend(16'h0040, "rwl");
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_eq("rwl_busy", 32'(fetch_busy), 32'd0);
    chk_eq("rwl_req", 32'(mem_req), 32'd0);
    chk_eq("rwl_addr", 32'(mem_addr), 32'd0);
    chk_eq("rwl_inst", 32'(inst), 32'd0);
    chk_eq("rwl_valid", 32'(inst_valid), 32'd0);
    for (int i = 0; i < 4; i++) step();
    chk_eq("rwl_stray_busy", 32'(fetch_busy), 32'd0);
    chk_eq("rwl_stray_inst", 32'(inst), 32'd0);
    chk_eq("rwl_stray_req", 32'(mem_req), 32'd0);
    rv_dly = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Multicycle instruction-fetch controller between the Rissy core and byte-wide program memory.
- Accepts a fetch address from the core and issues two byte reads to memory: low byte at addr, high byte at addr+1.
- Assembles a 16-bit little-endian instruction and presents it with a valid/ack handshake.
- Supports branch flush: in-flight memory responses are drained and discarded before a new fetch starts.

Parameters:
- ADDR_W, 16, width of fetch and memory byte addresses.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous active-high reset
- fetch_req  input  1  core requests an instruction at fetch_addr
- fetch_addr  input  ADDR_W  byte address of instruction (low byte)
- fetch_busy  output  1  sequencer not in IDLE
- inst  output  16  assembled instruction {byte@addr+1, byte@addr}
- inst_valid  output  1  inst holds a complete instruction
- inst_ack  input  1  core consumes inst this cycle
- flush  input  1  branch taken: abandon current fetch
- mem_req  output  1  byte read request
- mem_addr  output  ADDR_W  byte read address
- mem_gnt  input  1  memory accepts request this cycle
- mem_rvalid  input  1  read data valid; at most one outstanding read; arrives ≥1 cycle after gnt
- mem_rdata  input  8  read byte

Behaviour:
- Reset (synchronous, rst=1 at edge): state=IDLE; mem_req=0, mem_addr=0, inst=16'h0000, inst_valid=0, fetch_busy=0; latched address and low byte cleared. Reset overrides flush and every other input. Mid-operation reset abandons any outstanding read; a late mem_rvalid after reset is ignored while in IDLE.
- States: IDLE, REQ_LO, WAIT_LO, REQ_HI, WAIT_HI, HOLD, DRAIN.
- IDLE: if fetch_req and !flush, latch fetch_addr into addr_q, go to REQ_LO. A fetch_req with flush in the same cycle is ignored.
- REQ_LO: mem_req=1, mem_addr=addr_q. On mem_gnt go to WAIT_LO; otherwise hold request stable.
- WAIT_LO: on mem_rvalid, latch mem_rdata into lo_q and go to REQ_HI.
- REQ_HI: mem_req=1, mem_addr=addr_q+1 modulo 2^ADDR_W (all-ones wraps to 0). On mem_gnt go to WAIT_HI.
- WAIT_HI: on mem_rvalid, inst <= {mem_rdata, lo_q}, inst_valid <= 1, go to HOLD.
- HOLD: inst and inst_valid stay stable until inst_ack. On inst_ack: inst_valid <= 0.
  - If fetch_req is also high in that cycle, latch the new fetch_addr and go directly to REQ_LO (back-to-back).
  - Otherwise go to IDLE.
- Minimum latency: fetch_req at cycle 0 with gnt and rvalid each arriving one cycle after request gives inst_valid at cycle 5.
- mem_req is registered and asserted only in REQ_LO/REQ_HI. mem_addr is stable while mem_req=1 and !mem_gnt.
- Flush has priority over all transitions except reset:
  - IDLE, REQ_LO or REQ_HI without gnt, or HOLD: go to IDLE; inst_valid <= 0; no memory side effect. Withdrawing mem_req without gnt is legal.
  - REQ_LO or REQ_HI with mem_gnt in the same cycle: go to DRAIN, since a read is now outstanding.
  - WAIT_LO or WAIT_HI without mem_rvalid: go to DRAIN.
  - WAIT_LO or WAIT_HI with mem_rvalid in the same cycle: discard the data, go to IDLE.
- DRAIN: mem_req=0. On mem_rvalid, discard the data and go to IDLE. Flush while in DRAIN is absorbed. fetch_req is ignored until IDLE.
- inst_ack while inst_valid=0 is ignored.
- fetch_busy = (state != IDLE), registered.
- Odd fetch addresses are legal; no alignment check.

Test Plan:
- Single fetch: memory bytes [0x10]=0xa0, [0x11]=0x0b, 1-cycle gnt/rvalid; fetch_req addr=0x0010 -> mem_addr 0x0010 then 0x0011, inst=16'h0ba0 with inst_valid at cycle 5, held until inst_ack, then IDLE.
- Back-to-back fetches: inst_ack together with fetch_req addr=0x0002 ([2]=0x04, [3]=0x82) -> no IDLE cycle, next inst=16'h8204; mem_gnt held low 3 cycles -> mem_req and mem_addr stay stable.
- Wrap-around: ADDR_W=16, fetch_addr=16'hFFFF, [FFFF]=0xc5, [0000]=0x44 -> second mem_addr=16'h0000, inst=16'h44c5.
- Flush during WAIT_HI with rvalid delayed 3 cycles -> DRAIN. The late byte 0xEE is discarded, inst_valid never rises, and the next fetch of addr 0x0006 ([6]=0x20, [7]=0x02) returns 16'h0220.
- Flush coinciding with mem_gnt in REQ_LO -> DRAIN, then IDLE after rvalid. Flush in HOLD -> inst_valid low the next cycle.
- Reset asserted in WAIT_LO -> next cycle all outputs at reset values. A stray mem_rvalid afterwards leaves the block in IDLE with inst=0.
